reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared constants for the reorder buffer and its clients
package reorder_buffer_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Destination register code meaning "no architectural write"
  localparam logic [5:0] NULL = 6'd32;

  localparam int ENTRY_SIZE_DEF = 4;
  localparam logic [ENTRY_SIZE_DEF:0]   ENTRY_NULL  = 5'd16;
  localparam logic [ENTRY_SIZE_DEF-1:0] ENTRY_RANGE = 4'd15;

  // Null tag for an arbitrary entry width: one past the last slot index
  function automatic int entry_null(input int entry_size);
    return 1 << entry_size;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit queue with broadcast wakeup and branch rollback
// Optional ROB_QUERY_FWD_EN: operand queries also see same-cycle rs/lsb broadcasts.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ENTRY_SIZE = 4,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,

  input  logic                  new_issue,
  input  logic [5:0]            issue_rd,
  input  logic                  issue_is_branch,
  input  logic                  issue_is_store,
  input  logic                  issue_pred_taken,
  input  logic [31:0]           issue_pc,
  output logic [ENTRY_SIZE:0]   rob_new_entry,
  output logic                  rob_full,

  input  logic                  rs_broadcast,
  input  logic [ENTRY_SIZE:0]   rs_entry,
  input  logic [31:0]           rs_result,
  input  logic                  rs_jump,
  input  logic [31:0]           rs_target,
  input  logic                  lsb_broadcast,
  input  logic [ENTRY_SIZE:0]   lsb_entry,
  input  logic [31:0]           lsb_result,

  output logic                  rob_commit,
  output logic [ENTRY_SIZE:0]   rob_entry,
  output logic [5:0]            rob_des,
  output logic [31:0]           rob_result,
  output logic                  store_commit,
  output logic                  roll_back,
  output logic [31:0]           roll_back_pc,

  input  logic [ENTRY_SIZE:0]   qj_in,
  input  logic [ENTRY_SIZE:0]   qk_in,
  output logic                  qj_ready,
  output logic                  qk_ready,
  output logic [31:0]           qj_value,
  output logic [31:0]           qk_value
);

  localparam int DEPTH = 1 << ENTRY_SIZE;
  localparam logic [ENTRY_SIZE:0]   TAG_NULL = (ENTRY_SIZE+1)'(entry_null(ENTRY_SIZE));
  localparam logic [ENTRY_SIZE-1:0] IDX_ONE  = 1;

  logic [DEPTH-1:0]      busy, ready;
  logic [DEPTH-1:0]      is_branch_q, is_store_q, pred_q, jump_q;
  logic [5:0]            rd_q     [DEPTH];
  logic [31:0]           pc_q     [DEPTH];
  logic [31:0]           value_q  [DEPTH];
  logic [31:0]           target_q [DEPTH];

  logic [ENTRY_SIZE-1:0] head, tail;
  logic [ENTRY_SIZE:0]   count;

  logic [ENTRY_SIZE-1:0] rs_idx, lsb_idx;
  logic                  active, issue_ok, rs_hit, lsb_hit, do_commit, mispredict;

  assign rob_new_entry = {1'b0, tail};
  assign rob_full      = (count == TAG_NULL);

  // Nothing new enters while paused or during the rollback cycle
  assign active    = rdy_in && !roll_back;
  assign issue_ok  = active && new_issue && !rob_full;
  assign rs_idx    = rs_entry[ENTRY_SIZE-1:0];
  assign lsb_idx   = lsb_entry[ENTRY_SIZE-1:0];
  assign rs_hit    = active && rs_broadcast  && !rs_entry[ENTRY_SIZE]  && busy[rs_idx];
  assign lsb_hit   = active && lsb_broadcast && !lsb_entry[ENTRY_SIZE] && busy[lsb_idx];
  assign do_commit = active && (count != '0) && ready[head];
  assign mispredict = do_commit && is_branch_q[head] && (jump_q[head] != pred_q[head]);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      busy         <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      rob_commit   <= FALSE;
      store_commit <= FALSE;
      roll_back    <= FALSE;
      rob_entry    <= TAG_NULL;
      rob_des      <= NULL;
      rob_result   <= '0;
      roll_back_pc <= '0;
    end else begin
      rob_commit   <= FALSE;
      store_commit <= FALSE;
      roll_back    <= FALSE;
      if (rs_hit)  ready[rs_idx]  <= TRUE;
      if (lsb_hit) ready[lsb_idx] <= TRUE;
      if (do_commit) begin
        busy[head]  <= FALSE;
        ready[head] <= FALSE;
        head        <= head + IDX_ONE;
        rob_entry   <= {1'b0, head};
        rob_result  <= value_q[head];
        if (is_store_q[head]) begin
          store_commit <= TRUE;
          rob_des      <= NULL;
        end else begin
          rob_commit   <= TRUE;
          rob_des      <= rd_q[head];
        end
      end
      if (issue_ok) begin
        busy[tail]  <= TRUE;
        ready[tail] <= issue_is_store;
        tail        <= tail + IDX_ONE;
      end
      count <= count + (ENTRY_SIZE+1)'(issue_ok) - (ENTRY_SIZE+1)'(do_commit);
      // A mispredicted branch at head squashes everything younger, including same-cycle issue
      if (mispredict) begin
        roll_back    <= TRUE;
        roll_back_pc <= jump_q[head] ? target_q[head] : pc_q[head] + 32'd4;
        busy         <= '0;
        ready        <= '0;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_ok) begin
      rd_q[tail]        <= (int'(issue_rd) >= REG_NUM) ? NULL : issue_rd;
      is_branch_q[tail] <= issue_is_branch;
      is_store_q[tail]  <= issue_is_store;
      pred_q[tail]      <= issue_pred_taken;
      pc_q[tail]        <= issue_pc;
    end
    if (rs_hit) begin
      value_q[rs_idx]  <= rs_result;
      jump_q[rs_idx]   <= rs_jump;
      target_q[rs_idx] <= rs_target;
    end
    if (lsb_hit) value_q[lsb_idx] <= lsb_result;
  end

  logic [ENTRY_SIZE:0] q_tag [2];
  logic                q_rdy [2];
  logic [31:0]         q_val [2];

  assign q_tag[0] = qj_in;
  assign q_tag[1] = qk_in;
  assign qj_ready = q_rdy[0];
  assign qk_ready = q_rdy[1];
  assign qj_value = q_val[0];
  assign qk_value = q_val[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_rdy[i] = FALSE;
      q_val[i] = '0;
      if (!q_tag[i][ENTRY_SIZE]) begin
        q_rdy[i] = busy[q_tag[i][ENTRY_SIZE-1:0]] && ready[q_tag[i][ENTRY_SIZE-1:0]];
        q_val[i] = value_q[q_tag[i][ENTRY_SIZE-1:0]];
`ifdef ROB_QUERY_FWD_EN
        if (lsb_hit && lsb_entry == q_tag[i]) begin
          q_rdy[i] = TRUE;
          q_val[i] = lsb_result;
        end
        if (rs_hit && rs_entry == q_tag[i]) begin
          q_rdy[i] = TRUE;
          q_val[i] = rs_result;
        end
`endif
      end
    end
  end

endmodule
